memaccess: RTL and testbench

- MEM-stage data-memory access unit, directly downstream of the MEM-stage control register.
- Consumes the registered MemRd/MemWr strobes together with the ALU-computed address and store data.
- Runs a req/ack transaction on the data-memory port and returns load data for the write-back stage.
- Holds the pipeline with a stall signal until the access completes, is rejected, or times out.

---
 rtl/memaccess.sv | 126 ++++++++++++
 tb/tb_memaccess.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memaccess.sv
// MEM-stage data-memory access unit: issues one req/ack transaction per load/store,
// stalls the pipeline while it is outstanding, and reports completion, misalignment or timeout.
module memaccess #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memrdin,
    input  logic          memwrin,
    input  logic [AW-1:0] addrin,
    input  logic [DW-1:0] wdatain,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdataout,
    output logic          stall,
    output logic          done,
    output logic          err_align,
    output logic          err_timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          req_n, we_n, done_n, erra_n, errt_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] wdata_n, rdata_n;
    logic          valid, bad;

    // Request decode: exactly one strobe and a word-aligned address.
    assign valid = (memrdin ^ memwrin) && (addrin[1:0] == 2'b00);
    assign bad   = (memrdin & memwrin) || ((memrdin | memwrin) && (addrin[1:0] != 2'b00));

    // Held while a request is being accepted and for the whole outstanding access.
    assign stall = (state == BUSY) || ((state == IDLE) && valid);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = mem_req;
        we_n    = mem_we;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        rdata_n = rdataout;
        done_n  = 1'b0;
        erra_n  = 1'b0;
        errt_n  = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    state_n = BUSY;
                    req_n   = 1'b1;
                    we_n    = memwrin;
                    addr_n  = addrin;
                    wdata_n = wdatain;
                    cnt_n   = '0;
                end else if (bad) begin
                    erra_n = 1'b1;
                end
            end
            BUSY: begin
                // Counter tops out at TIMEOUT, which fits in CW bits.
                cnt_n = cnt + CW'(1);
                if (mem_ack) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                    done_n  = 1'b1;
                    if (!mem_we) begin
                        rdata_n = mem_rdata;
                    end
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                    rdata_n = '0;
                    done_n  = 1'b1;
                    errt_n  = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdataout    <= '0;
            done        <= 1'b0;
            err_align   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            mem_req     <= req_n;
            mem_we      <= we_n;
            mem_addr    <= addr_n;
            mem_wdata   <= wdata_n;
            rdataout    <= rdata_n;
            done        <= done_n;
            err_align   <= erra_n;
            err_timeout <= errt_n;
        end
    end

endmodule

// File: tb/tb_memaccess.sv
// Bench for memaccess: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_memaccess;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          memrdin, memwrin, mem_ack;
    logic [AW-1:0] addrin;
    logic [DW-1:0] wdatain, mem_rdata;
    logic          mem_req, mem_we, stall, done, err_align, err_timeout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rdataout;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    memaccess #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .memrdin(memrdin), .memwrin(memwrin),
        .addrin(addrin), .wdatain(wdatain), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .rdataout(rdataout), .stall(stall), .done(done),
        .err_align(err_align), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: an access is either absent, outstanding (with a count
    // of elapsed busy cycles), or in its one-cycle wrap-up.
    bit          m_out, m_wrap;
    int          m_elapsed;
    logic        e_req, e_we, e_done, e_erra, e_errt;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;

    always @(posedge clk) begin
        if (rst) begin
            m_out = 0; m_wrap = 0; m_elapsed = 0;
            e_req = 0; e_we = 0; e_done = 0; e_erra = 0; e_errt = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
        end else begin
            e_done = 0; e_erra = 0; e_errt = 0;
            if (m_wrap) begin
                m_wrap = 0;
            end else if (m_out) begin
                m_elapsed++;
                if (mem_ack) begin
                    m_out = 0; m_wrap = 1; e_req = 0; e_done = 1;
                    if (!e_we) e_rdata = mem_rdata;
                end else if (m_elapsed == int'(TO)) begin
                    m_out = 0; m_wrap = 1; e_req = 0; e_done = 1; e_errt = 1; e_rdata = '0;
                end
            end else if (memrdin != memwrin && addrin % 4 == 0) begin
                m_out = 1; m_elapsed = 0; e_req = 1; e_we = memwrin;
                e_addr = addrin; e_wdata = wdatain;
            end else if (memrdin || memwrin) begin
                e_erra = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic e_stall;
            e_stall = m_out || (!m_wrap && memrdin != memwrin && addrin % 4 == 0);
            chk("mem_req",     64'(mem_req),     64'(e_req));
            chk("mem_we",      64'(mem_we),      64'(e_we));
            chk("mem_addr",    64'(mem_addr),    64'(e_addr));
            chk("mem_wdata",   64'(mem_wdata),   64'(e_wdata));
            chk("rdataout",    64'(rdataout),    64'(e_rdata));
            chk("done",        64'(done),        64'(e_done));
            chk("err_align",   64'(err_align),   64'(e_erra));
            chk("err_timeout", 64'(err_timeout), 64'(e_errt));
            chk("stall",       64'(stall),       64'(e_stall));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ack_pct;
        rst = 1'b1; memrdin = 0; memwrin = 0; mem_ack = 0;
        addrin = '0; wdatain = '0; mem_rdata = '0;
        step();
        chk_en = 1'b1;
        step();
        chk("reset_req", 64'(mem_req), 64'd0);
        chk("reset_rdata", 64'(rdataout), 64'd0);
        rst = 1'b0;
        step();

        // Zero-wait load
        memrdin = 1; addrin = 32'h40;
        #1 chk("t1_stall_idle", 64'(stall), 64'd1);
        step();
        memrdin = 0; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        #1 chk("t1_req", 64'(mem_req), 64'd1);
        chk("t1_we", 64'(mem_we), 64'd0);
        chk("t1_stall_busy", 64'(stall), 64'd1);
        step();
        mem_ack = 0;
        #1 chk("t1_done", 64'(done), 64'd1);
        chk("t1_rdata", 64'(rdataout), 64'hDEADBEEF);
        chk("t1_stall_done", 64'(stall), 64'd0);
        step();

        // Store with 3 wait states
        memwrin = 1; addrin = 32'h100; wdatain = 32'h12345678;
        step();
        memwrin = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            #1 chk("t2_req", 64'(mem_req), 64'd1);
            chk("t2_addr", 64'(mem_addr), 64'h100);
            chk("t2_wdata", 64'(mem_wdata), 64'h12345678);
            step();
        end
        mem_ack = 0;
        #1 chk("t2_rdata_kept", 64'(rdataout), 64'hDEADBEEF);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_stall", 64'(stall), 64'd0);
        step();

        // Misaligned, then illegal rd+wr
        memrdin = 1; addrin = 32'h102;
        #1 chk("t3_stall_mis", 64'(stall), 64'd0);
        step();
        memrdin = 0;
        #1 chk("t3_err_mis", 64'(err_align), 64'd1);
        chk("t3_req_mis", 64'(mem_req), 64'd0);
        step();
        #1 chk("t3_err_clear", 64'(err_align), 64'd0);
        memrdin = 1; memwrin = 1; addrin = 32'h0;
        #1 chk("t3_stall_ill", 64'(stall), 64'd0);
        step();
        memrdin = 0; memwrin = 0;
        #1 chk("t3_err_ill", 64'(err_align), 64'd1);
        chk("t3_req_ill", 64'(mem_req), 64'd0);
        step();

        // Timeout, then ack on the last allowed cycle
        for (int rep = 0; rep < 2; rep++) begin
            memrdin = 1; addrin = 32'h200;
            step();
            memrdin = 0; mem_rdata = 32'hCAFEF00D;
            for (int k = 0; k < int'(TO); k++) begin
                mem_ack = (rep == 1) && (k == int'(TO) - 1);
                #1 chk("t4_req", 64'(mem_req), 64'd1);
                step();
            end
            mem_ack = 0;
            #1 chk("t4_req_off", 64'(mem_req), 64'd0);
            chk("t4_done", 64'(done), 64'd1);
            chk("t4_errt", 64'(err_timeout), (rep == 0) ? 64'd1 : 64'd0);
            chk("t4_rdata", 64'(rdataout), (rep == 0) ? 64'd0 : 64'hCAFEF00D);
            step();
        end

        // Reset mid-access with a late ack
        memrdin = 1; addrin = 32'h300;
        step();
        memrdin = 0;
        step();
        rst = 1;
        step();
        rst = 0; mem_ack = 1; mem_rdata = 32'h55;
        #1 chk("t5_req", 64'(mem_req), 64'd0);
        chk("t5_addr", 64'(mem_addr), 64'd0);
        chk("t5_rdata", 64'(rdataout), 64'd0);
        chk("t5_stall", 64'(stall), 64'd0);
        step();
        mem_ack = 0;
        #1 chk("t5_done_late", 64'(done), 64'd0);
        chk("t5_rdata_late", 64'(rdataout), 64'd0);
        memrdin = 1; addrin = 32'h8;
        step();
        memrdin = 0; mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
        step();
        mem_ack = 0;
        #1 chk("t5_next_done", 64'(done), 64'd1);
        chk("t5_next_rdata", 64'(rdataout), 64'hA5A5A5A5);
        step();

        // Back-to-back load then store
        memrdin = 1; addrin = 32'h0;
        step();
        memrdin = 0; mem_ack = 1; mem_rdata = 32'h11;
        step();
        mem_ack = 0; memwrin = 1; addrin = 32'h4; wdatain = 32'h22;
        #1 chk("t6_no_req_done", 64'(mem_req), 64'd0);
        chk("t6_stall_done", 64'(stall), 64'd0);
        step();
        #1 chk("t6_req_idle", 64'(mem_req), 64'd0);
        chk("t6_stall_idle", 64'(stall), 64'd1);
        step();
        memwrin = 0; mem_ack = 1;
        #1 chk("t6_req2", 64'(mem_req), 64'd1);
        chk("t6_we2", 64'(mem_we), 64'd1);
        chk("t6_addr2", 64'(mem_addr), 64'h4);
        step();
        mem_ack = 0;
        step();

        // Random traffic with varying memory responsiveness
        ack_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) ack_pct = ($urandom_range(0, 1) == 1) ? 50 : 3;
            rst       = ($urandom_range(0, 299) == 0);
            memrdin   = ($urandom_range(0, 2) == 0);
            memwrin   = ($urandom_range(0, 3) == 0);
            addrin    = $urandom();
            if ($urandom_range(0, 3) != 0) addrin[1:0] = 2'b00;
            wdatain   = $urandom();
            mem_rdata = $urandom();
            mem_ack   = ($urandom_range(0, 99) < ack_pct);
            step();
        end
        rst = 0; memrdin = 0; memwrin = 0; mem_ack = 0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
